// File: rtl/logicnets_readout_pkg.sv
// rtl/logicnets_readout_pkg.sv - shared readout types: FSM states, counter width, result record
package logicnets_readout_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Population result as handed to the result FIFO / stream bridge.
    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] ones;
        logic [CNT_W_DEFAULT-1:0] total;
    } result_t;

endpackage

// File: rtl/logicnets_shot_accumulator_if.sv
// rtl/logicnets_shot_accumulator_if.sv - prediction beat input and result output bundle (LOGICNETS_MAJORITY_EN adds m_state)
interface logicnets_shot_accumulator_if #(
    parameter int CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic             s_bit;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] m_ones;
    logic [CNT_W-1:0] m_total;
`ifdef LOGICNETS_MAJORITY_EN
    logic             m_state;
`endif

`ifdef LOGICNETS_MAJORITY_EN
    modport master (
        output s_valid, s_bit, m_ready,
        input  s_ready, m_valid, m_ones, m_total, m_state
    );

    modport slave (
        input  s_valid, s_bit, m_ready,
        output s_ready, m_valid, m_ones, m_total, m_state
    );
`else
    modport master (
        output s_valid, s_bit, m_ready,
        input  s_ready, m_valid, m_ones, m_total
    );

    modport slave (
        input  s_valid, s_bit, m_ready,
        output s_ready, m_valid, m_ones, m_total
    );
`endif

endinterface

// File: rtl/logicnets_shot_accumulator.sv
// rtl/logicnets_shot_accumulator.sv - counts predicted |1> shots over a run; LOGICNETS_MAJORITY_EN adds majority m_state
module logicnets_shot_accumulator
    import logicnets_readout_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_W-1:0]              cfg_shots,
    output logic                          busy,
    logicnets_shot_accumulator_if.slave   bus
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] ones;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] ones_nxt;
    logic [CNT_W-1:0] total_nxt;
    logic             s_ready_q;
    logic             m_valid_q;
    logic             busy_q;
    logic             beat;

    // s_ready_q is only ever high in ACCUM, so it doubles as the state qualifier.
    assign beat = bus.s_valid & s_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ones_nxt  = ones;
        total_nxt = total;
        case (state)
            IDLE: begin
                if (start) begin
                    ones_nxt  = '0;
                    total_nxt = '0;
                    state_nxt = (cfg_shots == '0) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    total_nxt = total + CNT_W'(1);
                    ones_nxt  = ones + CNT_W'(bus.s_bit);
                    if (total_nxt == target) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (m_valid_q && bus.m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            target    <= '0;
            ones      <= '0;
            total     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                target <= cfg_shots;
            end
            ones      <= ones_nxt;
            total     <= total_nxt;
            s_ready_q <= (state_nxt == ACCUM);
            m_valid_q <= (state_nxt == HOLD);
            busy_q    <= (state_nxt != IDLE);
        end
    end

`ifdef LOGICNETS_MAJORITY_EN
    logic m_state_q;

    // Evaluated one bit wider so 2*ones cannot wrap; ties and empty runs give 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_state_q <= 1'b0;
        end else if (state != HOLD && state_nxt == HOLD) begin
            m_state_q <= ({ones_nxt, 1'b0} > {1'b0, total_nxt});
        end
    end

    assign bus.m_state = m_state_q;
`endif

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_ones  = ones;
    assign bus.m_total = total;
    assign busy        = busy_q;

endmodule

// File: tb/tb_logicnets_shot_accumulator.sv
// tb/tb_logicnets_shot_accumulator.sv - scoreboard bench for the shot accumulator (LOGICNETS_MAJORITY_EN aware)
module tb_logicnets_shot_accumulator;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] cfg_shots;
    logic         busy;

    logicnets_shot_accumulator_if #(.CNT_W(W)) bus ();

    logicnets_shot_accumulator #(.CNT_W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_shots (cfg_shots),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ones;
        logic [W-1:0] total;
        logic         maj;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int o, input int t, input logic m);
        exp_t e;
        e.ones  = W'(o);
        e.total = W'(t);
        e.maj   = m;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got ones=%0d total=%0d required no result", bus.m_ones, bus.m_total);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_m_ones", 32'(bus.m_ones), 32'(e.ones));
                check("sb_m_total", 32'(bus.m_total), 32'(e.total));
`ifdef LOGICNETS_MAJORITY_EN
                check("sb_m_state", 32'(bus.m_state), 32'(e.maj));
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int cfg);
        cfg_shots = W'(cfg);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // bits[0] is sent first, one beat per cycle.
    task automatic beats(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.s_valid = 1'b1;
            bus.s_bit   = bits[i];
            step();
        end
        bus.s_valid = 1'b0;
        bus.s_bit   = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;
        rst         = 1'b1;
        start       = 1'b0;
        cfg_shots   = '0;
        bus.s_valid = 1'b0;
        bus.s_bit   = 1'b0;
        bus.m_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_s_ready", 32'(bus.s_ready), 0);
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_m_ones", 32'(bus.m_ones), 0);
        check("rst_m_total", 32'(bus.m_total), 0);

        // 8 back-to-back beats 1,0,1,1,0,0,1,1 -> 5/8
        push_exp(5, 8, 1'b1);
        do_start(8);
        check("t1_s_ready_first", 32'(bus.s_ready), 1);
        check("t1_busy", 32'(busy), 1);
        beats(16'h004D, 7);
        check("t1_m_valid_early", 32'(bus.m_valid), 0);
        check("t1_s_ready_mid", 32'(bus.s_ready), 1);
        beats(16'h0001, 1);
        check("t1_m_valid_latency", 32'(bus.m_valid), 1);
        check("t1_s_ready_hold", 32'(bus.s_ready), 0);
        step();
        check("t1_idle_m_valid", 32'(bus.m_valid), 0);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_idle_keep_total", 32'(bus.m_total), 8);

        // gapped s_valid 1,0,0,1,1,0,1 with all ones, target 4
        push_exp(4, 4, 1'b1);
        bus.m_ready = 1'b0;
        do_start(4);
        pat = 7'b1011001;
        for (int i = 0; i < 7; i++) begin
            bus.s_valid = pat[i];
            bus.s_bit   = 1'b1;
            step();
        end
        check("t2_m_valid", 32'(bus.m_valid), 1);
        for (int i = 0; i < 3; i++) begin
            check("t2_no_extra_ready", 32'(bus.s_ready), 0);
            check("t2_no_extra_total", 32'(bus.m_total), 4);
            step();
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        step();

        // empty run
        push_exp(0, 0, 1'b0);
        do_start(0);
        check("t3_m_valid", 32'(bus.m_valid), 1);
        check("t3_busy", 32'(busy), 1);
        check("t3_s_ready", 32'(bus.s_ready), 0);
        step();
        check("t3_done", 32'(bus.m_valid), 0);

        // stall in HOLD while pulsing start
        bus.m_ready = 1'b0;
        push_exp(2, 3, 1'b1);
        do_start(3);
        beats(16'h0005, 3);
        for (int i = 0; i < 10; i++) begin
            start     = 1'b1;
            cfg_shots = W'(7);
            step();
            check("t4_m_valid_stable", 32'(bus.m_valid), 1);
            check("t4_m_ones_stable", 32'(bus.m_ones), 2);
            check("t4_m_total_stable", 32'(bus.m_total), 3);
            check("t4_no_restart", 32'(bus.s_ready), 0);
        end
        bus.m_ready = 1'b1;
        step();
        start = 1'b0;
        check("t4_idle_busy", 32'(busy), 0);
        check("t4_idle_s_ready", 32'(bus.s_ready), 0);
        check("t4_idle_m_valid", 32'(bus.m_valid), 0);
        push_exp(0, 1, 1'b0);
        do_start(1);
        check("t4_restart_ready", 32'(bus.s_ready), 1);
        beats(16'h0000, 1);
        step();

        // reset mid-run
        do_start(6);
        beats(16'h0007, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_m_ones", 32'(bus.m_ones), 0);
        check("t5_m_total", 32'(bus.m_total), 0);
        check("t5_s_ready", 32'(bus.s_ready), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_m_valid", 32'(bus.m_valid), 0);
        push_exp(2, 2, 1'b1);
        do_start(2);
        beats(16'h0003, 2);
        step();

        // majority: tie then strict majority
        push_exp(2, 4, 1'b0);
        do_start(4);
        beats(16'h0003, 4);
        step();
        push_exp(3, 4, 1'b1);
        do_start(4);
        beats(16'h0007, 4);
        step();

        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        check("scoreboard_drain", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
